// File: rtl/tk1_exec_mon.sv
// Execution monitor for the tk1 core: NUM_REGIONS lockable no-execute windows,
// violation capture and trap blink. Define TK1_EXEC_MON_FW_GUARD_EN to add the fixed firmware RAM guard.
module tk1_exec_mon #(
  parameter int          NUM_REGIONS  = 4,
  parameter int          BLINK_BITS   = 24,
  parameter logic [31:0] FW_RAM_FIRST = 32'hd0000000,
  parameter logic [31:0] FW_RAM_LAST  = 32'hd00007ff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_trap,
  input  logic        fw_app_mode,
  input  logic [2:0]  led_in,
  output logic [2:0]  led_out,
  output logic        force_trap,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

`ifdef TK1_EXEC_MON_FW_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_VADDR  = 8'h02;
  localparam logic [7:0] ADDR_VCOUNT = 8'h03;
  localparam logic [7:0] ADDR_CLEAR  = 8'h04;

  logic [NUM_REGIONS-1:0] en_q;
  logic                   lock_q;
  logic [31:0]            first_q [NUM_REGIONS];
  logic [31:0]            last_q  [NUM_REGIONS];
  logic                   viol_q;
  logic [2:0]             idx_q;
  logic [31:0]            vaddr_q;
  logic [15:0]            vcount_q;
  logic [BLINK_BITS-1:0]  blink_cnt_q;
  logic [2:0]             blink_q;

  logic                   wr;
  logic                   clear_wr;
  logic                   fetch;
  logic                   fw_hit;
  logic [NUM_REGIONS-1:0] region_hit;
  logic                   viol_hit;
  logic [2:0]             hit_idx;

  // Bus handshake: ready mirrors cs, so every selected access completes in the
  // cycle it is presented; reads are combinational, writes commit on that edge.
  assign ready    = cs;
  assign wr       = cs & we;
  assign clear_wr = wr & (address == ADDR_CLEAR) & ~fw_app_mode;
  assign fetch    = cpu_valid & cpu_instr;
  assign fw_hit   = GUARD_EN & fetch & (cpu_addr >= FW_RAM_FIRST) & (cpu_addr <= FW_RAM_LAST);

  always_comb begin
    region_hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      region_hit[i] = fetch & en_q[i] & (cpu_addr >= first_q[i]) & (cpu_addr <= last_q[i]);
    end
  end

  // Scan downwards so the lowest hitting region wins; the guard overrides all.
  always_comb begin
    viol_hit = 1'b0;
    hit_idx  = 3'd0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (region_hit[i]) begin
        viol_hit = 1'b1;
        hit_idx  = 3'(i);
      end
    end
    if (fw_hit) begin
      viol_hit = 1'b1;
      hit_idx  = 3'd7;
    end
  end

  assign force_trap = viol_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      lock_q <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        first_q[i] <= '0;
        last_q[i]  <= '0;
      end
    end else if (wr && !lock_q) begin
      if (address == ADDR_CTRL) begin
        en_q   <= en_q | write_data[NUM_REGIONS-1:0];
        lock_q <= write_data[31];
      end
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (!en_q[i] && address == 8'(16 + 2 * i)) first_q[i] <= write_data;
        if (!en_q[i] && address == 8'(17 + 2 * i)) last_q[i]  <= write_data;
      end
    end
  end

  // A clear in the same cycle as a hit is applied first, so the hit recaptures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_q   <= 1'b0;
      idx_q    <= 3'd0;
      vaddr_q  <= '0;
      vcount_q <= '0;
    end else begin
      if (clear_wr) begin
        viol_q   <= 1'b0;
        idx_q    <= 3'd0;
        vaddr_q  <= '0;
        vcount_q <= '0;
      end
      if (viol_hit) begin
        if (!viol_q || clear_wr) begin
          viol_q  <= 1'b1;
          idx_q   <= hit_idx;
          vaddr_q <= cpu_addr;
        end
        if (clear_wr) vcount_q <= 16'd1;
        else if (vcount_q != 16'hffff) vcount_q <= vcount_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 3'h0;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
      if (blink_cnt_q == '0) blink_q <= blink_q ^ 3'h4;
    end
  end

  assign led_out = cpu_trap ? blink_q : led_in;

  always_comb begin
    read_data = '0;
    case (address)
      ADDR_CTRL: begin
        read_data[31]               = lock_q;
        read_data[NUM_REGIONS-1:0]  = en_q;
      end
      ADDR_STATUS: begin
        read_data[0]   = viol_q;
        read_data[6:4] = idx_q;
      end
      ADDR_VADDR:  read_data = vaddr_q;
      ADDR_VCOUNT: read_data = {16'h0, vcount_q};
      default: begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (address == 8'(16 + 2 * i)) read_data = first_q[i];
          if (address == 8'(17 + 2 * i)) read_data = last_q[i];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_tk1_exec_mon.sv
// Directed self-checking bench for tk1_exec_mon (BLINK_BITS = 4 so the blink period is short).
module tb_tk1_exec_mon;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid, cpu_instr, cpu_trap, fw_app_mode;
  logic [31:0] cpu_addr;
  logic [2:0]  led_in, led_out;
  logic        force_trap;
  logic        cs, we, ready;
  logic [7:0]  address;
  logic [31:0] write_data, read_data;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef TK1_EXEC_MON_FW_GUARD_EN
  localparam logic [31:0] GUARD_STATUS = 32'h71;
`else
  localparam logic [31:0] GUARD_STATUS = 32'h11;
`endif

  tk1_exec_mon #(.BLINK_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_trap(cpu_trap), .fw_app_mode(fw_app_mode),
    .led_in(led_in), .led_out(led_out), .force_trap(force_trap),
    .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // driver tasks: inputs change on the falling edge, DUT samples on the rising edge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    check(tag, read_data, exp);
    cs = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic instr, input logic exp_trap);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = a;
    #1;
    check(tag, {31'h0, force_trap}, {31'h0, exp_trap});
    @(negedge clk);
    cpu_valid = 1'b0; cpu_instr = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check({tag, "_led"}, {29'h0, led_out}, {29'h0, led_in});
    check({tag, "_trap"}, {31'h0, force_trap}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0;
    cpu_trap = 1'b0; fw_app_mode = 1'b0; led_in = 3'h3;
    cs = 1'b0; we = 1'b0; address = '0; write_data = '0;

    // reset state
    #12;
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_trap", {31'h0, force_trap}, 32'h0);
    check("rst_led", {29'h0, led_out}, 32'h3);
    @(negedge clk);
    reset = 1'b0;
    read_check("rst_ctrl", 8'h00, 32'h0);
    read_check("rst_status", 8'h01, 32'h0);
    read_check("rst_vaddr", 8'h02, 32'h0);
    read_check("rst_vcount", 8'h03, 32'h0);
    read_check("rst_first0", 8'h10, 32'h0);
    @(negedge clk);
    cs = 1'b1; address = 8'h01; #1;
    check("ready_cs", {31'h0, ready}, 32'h1);
    cs = 1'b0;

    // region 0 hit and capture
    bus_write(8'h10, 32'h40000100);
    bus_write(8'h11, 32'h400001ff);
    bus_write(8'h00, 32'h1);
    fetch("r0_hit_trap", 32'h40000100, 1'b1, 1'b1);
    read_check("r0_status", 8'h01, 32'h01);
    read_check("r0_vaddr", 8'h02, 32'h40000100);
    read_check("r0_vcount", 8'h03, 32'h1);
    fetch("r0_above", 32'h40000200, 1'b1, 1'b0);
    fetch("r0_data_acc", 32'h40000150, 1'b0, 1'b0);
    fetch("r0_last_trap", 32'h400001ff, 1'b1, 1'b1);
    read_check("r0_vaddr_frozen", 8'h02, 32'h40000100);
    read_check("r0_vcount2", 8'h03, 32'h2);
    bus_write(8'h10, 32'h0);
    read_check("r0_first_en_locked", 8'h10, 32'h40000100);

    // lock
    bus_write(8'h00, 32'h80000001);
    read_check("lock_ctrl", 8'h00, 32'h80000001);
    bus_write(8'h12, 32'h1234);
    bus_write(8'h00, 32'h2);
    read_check("lock_ctrl_kept", 8'h00, 32'h80000001);
    read_check("lock_first1", 8'h12, 32'h0);

    // asynchronous reset clears everything including LOCK
    pulse_reset("rst1");
    read_check("rst1_ctrl", 8'h00, 32'h0);
    read_check("rst1_status", 8'h01, 32'h0);
    read_check("rst1_vcount", 8'h03, 32'h0);
    read_check("rst1_first0", 8'h10, 32'h0);

    // blink: reset released on a falling edge, so the k-th rising edge after it
    // leaves blink = 4 for k in 1..16, 0 for 17..32, 4 for 33..48
    pulse_reset("rst2");
    cpu_trap = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1 || k == 16 || k == 17 || k == 32 || k == 33 || k == 40)
        check($sformatf("blink_k%0d", k), {29'h0, led_out},
              (((k - 1) / 16) % 2 == 0) ? 32'h4 : 32'h0);
    end
    cpu_trap = 1'b0;
    #1;
    check("blink_drop", {29'h0, led_out}, 32'h3);

    // region 1 over the firmware RAM (guard index 7 when the guard is built in)
    bus_write(8'h12, 32'hd0000000);
    bus_write(8'h13, 32'hd0000fff);
    bus_write(8'h00, 32'h2);
    fetch("g_trap", 32'hd0000004, 1'b1, 1'b1);
    read_check("g_status", 8'h01, GUARD_STATUS);
    fetch("g_trap2", 32'hd0000008, 1'b1, 1'b1);
    read_check("g_vaddr", 8'h02, 32'hd0000004);
    read_check("g_vcount", 8'h03, 32'h2);

    // inverted region never hits
    bus_write(8'h16, 32'h2000);
    bus_write(8'h17, 32'h1000);
    bus_write(8'h00, 32'h8);
    fetch("inv_mid", 32'h00001800, 1'b1, 1'b0);
    fetch("inv_first", 32'h00002000, 1'b1, 1'b0);
    read_check("ctrl_or", 8'h00, 32'ha);

    // CLEAR in the same cycle as a region-2 hit
    bus_write(8'h14, 32'h1000);
    bus_write(8'h15, 32'h10ff);
    bus_write(8'h00, 32'h4);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = 8'h04; write_data = 32'h1;
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'h1000;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0;
    read_check("clr_hit_status", 8'h01, 32'h21);
    read_check("clr_hit_vaddr", 8'h02, 32'h1000);
    read_check("clr_hit_vcount", 8'h03, 32'h1);
    fw_app_mode = 1'b1;
    bus_write(8'h04, 32'h1);
    read_check("app_status", 8'h01, 32'h21);
    read_check("app_vaddr", 8'h02, 32'h1000);
    read_check("app_vcount", 8'h03, 32'h1);
    fw_app_mode = 1'b0;
    bus_write(8'h04, 32'h1);
    read_check("clr_status", 8'h01, 32'h0);
    read_check("clr_vaddr", 8'h02, 32'h0);
    read_check("clr_vcount", 8'h03, 32'h0);

    // unmapped space
    read_check("unmapped_05", 8'h05, 32'h0);
    bus_write(8'h18, 32'hdeadbeef);
    read_check("unmapped_18", 8'h18, 32'h0);

    // saturation, then reset while the hit is still held
    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'h1010;
    repeat (70000) @(negedge clk);
    #1;
    check("sat_trap", {31'h0, force_trap}, 32'h1);
    read_check("sat_vcount", 8'h03, 32'hffff);
    pulse_reset("rst3");
    cpu_valid = 1'b0; cpu_instr = 1'b0;
    read_check("rst3_ctrl", 8'h00, 32'h0);
    read_check("rst3_status", 8'h01, 32'h0);
    read_check("rst3_vaddr", 8'h02, 32'h0);
    read_check("rst3_vcount", 8'h03, 32'h0);
    read_check("rst3_first2", 8'h14, 32'h0);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
